// File: rtl/iigs_bus_pkg.sv
// Shared types and constants for the iigs CPU-side memory responder.
package iigs_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC,
    ST_DATA,
    ST_SWAIT,
    ST_SACC,
    ST_SDATA,
    ST_RESP
  } state_e;

  typedef enum logic [2:0] {
    TGT_NONE,
    TGT_FAST,
    TGT_SLOW,
    TGT_ROM1,
    TGT_ROM2
  } target_e;

  localparam logic [7:0] BANK_00 = 8'h00;
  localparam logic [7:0] BANK_01 = 8'h01;
  localparam logic [7:0] BANK_E0 = 8'hE0;
  localparam logic [7:0] BANK_E1 = 8'hE1;
  localparam logic [7:0] BANK_FE = 8'hFE;
  localparam logic [7:0] BANK_FF = 8'hFF;

  localparam int unsigned SHD_TEXT1 = 0;
  localparam int unsigned SHD_HGR1  = 1;
  localparam int unsigned SHD_HGR2  = 2;
  localparam int unsigned SHD_SHR   = 3;
  localparam int unsigned SHD_TEXT2 = 5;

  localparam logic [15:0] TEXT1_LO = 16'h0400;
  localparam logic [15:0] TEXT1_HI = 16'h07FF;
  localparam logic [15:0] TEXT2_LO = 16'h0800;
  localparam logic [15:0] TEXT2_HI = 16'h0BFF;
  localparam logic [15:0] HGR1_LO  = 16'h2000;
  localparam logic [15:0] HGR1_HI  = 16'h3FFF;
  localparam logic [15:0] HGR2_LO  = 16'h4000;
  localparam logic [15:0] HGR2_HI  = 16'h5FFF;
  localparam logic [15:0] SHR_LO   = 16'h2000;
  localparam logic [15:0] SHR_HI   = 16'h9FFF;
  localparam logic [15:0] ROM2_LO  = 16'hC100;

  // Target priority: rom1 > rom2 > fast > slow > unmapped.
  function automatic target_e decode_target(input logic [7:0] bank, input logic [15:0] addr,
                                            input int unsigned ramsize);
    if (bank == BANK_FE) return TGT_ROM1;
    if (bank == BANK_FF || (bank == BANK_00 && addr >= ROM2_LO)) return TGT_ROM2;
    if (32'(bank) < ramsize) return TGT_FAST;
    if (bank == BANK_E0 || bank == BANK_E1) return TGT_SLOW;
    return TGT_NONE;
  endfunction

  // Memory-side address for each target.
  function automatic logic [22:0] target_addr(input target_e tgt, input logic [7:0] bank,
                                              input logic [15:0] addr);
    case (tgt)
      TGT_FAST: return {bank[6:0], addr};
      TGT_SLOW: return {6'b0, bank[0], addr};
      default:  return {7'b0, addr};
    endcase
  endfunction

endpackage

// File: rtl/iigs_shadow_decode.sv
// Combinational shadow-write detector for bank 00/01 video regions.
module iigs_shadow_decode
  import iigs_bus_pkg::*;
(
  input  logic [7:0]  bank,
  input  logic [15:0] addr,
  input  logic        we,
  input  logic [7:0]  shadow,
  output logic        shadow_hit
);

  logic in_text1, in_text2, in_hgr1, in_hgr2, in_shr;
  logic unused_shadow_bits;

  assign in_text1 = (addr >= TEXT1_LO) && (addr <= TEXT1_HI);
  assign in_text2 = (addr >= TEXT2_LO) && (addr <= TEXT2_HI);
  assign in_hgr1  = (addr >= HGR1_LO)  && (addr <= HGR1_HI);
  assign in_hgr2  = (addr >= HGR2_LO)  && (addr <= HGR2_HI);
  assign in_shr   = (addr >= SHR_LO)   && (addr <= SHR_HI);

  assign unused_shadow_bits = &{1'b0, shadow[7:6], shadow[4]};

  // In bank 01 the super-hires window is governed by its own bit alone,
  // overriding the hgr bits that would otherwise overlap it.
  always_comb begin
    shadow_hit = 1'b0;
    if (we && (bank == BANK_00 || bank == BANK_01)) begin
      if (bank == BANK_01 && in_shr) begin
        shadow_hit = !shadow[SHD_SHR];
      end else begin
        shadow_hit = (in_text1 && !shadow[SHD_TEXT1]) ||
                     (in_text2 && !shadow[SHD_TEXT2]) ||
                     (in_hgr1  && !shadow[SHD_HGR1])  ||
                     (in_hgr2  && !shadow[SHD_HGR2]);
      end
    end
  end

endmodule

// File: rtl/iigs_mem_responder.sv
// CPU-side bus responder: decodes requests, stretches slow-bank accesses
// to the 1 MHz slot and mirrors shadowed bank 00/01 writes into E0/E1.
module iigs_mem_responder
  import iigs_bus_pkg::*;
#(
  parameter int unsigned RAMSIZE  = 2,
  parameter int unsigned SLOW_DIV = 28
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [7:0]  cpu_bank,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  output logic        cpu_ready,
  output logic [7:0]  cpu_rdata,
  input  logic        fast_mode,
  input  logic [7:0]  shadow,
  output logic [22:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        fast_ce,
  output logic        slow_ce,
  output logic        rom1_ce,
  output logic        rom2_ce,
  input  logic [7:0]  fast_q,
  input  logic [7:0]  slow_q,
  input  logic [7:0]  rom1_q,
  input  logic [7:0]  rom2_q,
  output logic        slot
);

  localparam int unsigned CNT_W = $clog2(SLOW_DIV);

  logic [CNT_W-1:0] slot_cnt;
  state_e           state;
  target_e          req_tgt;
  logic [7:0]       req_bank;
  logic [15:0]      req_addr;
  logic [7:0]       req_wdata;
  logic             req_we;
  logic             req_shadow;
  logic             acc_done;

  target_e          in_tgt;
  logic             sd_hit;
  logic             in_hit;
  target_e          acc_tgt;
  logic [7:0]       acc_bank;
  logic [15:0]      acc_addr;
  logic [7:0]       acc_wdata;
  logic             acc_we;
  logic             go_acc;
  logic             go_sacc;

  iigs_shadow_decode u_shadow (
    .bank       (cpu_bank),
    .addr       (cpu_addr),
    .we         (cpu_we),
    .shadow     (shadow),
    .shadow_hit (sd_hit)
  );

  assign in_tgt = decode_target(cpu_bank, cpu_addr, RAMSIZE);
  assign in_hit = sd_hit && (in_tgt == TGT_FAST);
  assign slot   = (slot_cnt == CNT_W'(SLOW_DIV - 1));

  // Free-running 1 MHz slot counter.
  always_ff @(posedge clk_sys) begin
    if (reset) slot_cnt <= '0;
    else if (slot) slot_cnt <= '0;
    else slot_cnt <= slot_cnt + 1'b1;
  end

  // Access source: live request fields straight out of IDLE, latched ones afterwards.
  always_comb begin
    if (state == ST_IDLE) begin
      acc_tgt   = in_tgt;
      acc_bank  = cpu_bank;
      acc_addr  = cpu_addr;
      acc_wdata = cpu_wdata;
      acc_we    = cpu_we;
    end else begin
      acc_tgt   = req_tgt;
      acc_bank  = req_bank;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_we    = req_we;
    end
  end

  // Cycles on which the FSM moves into ACC or SACC and drives the memory bus.
  always_comb begin
    go_acc  = 1'b0;
    go_sacc = 1'b0;
    if (state == ST_IDLE) begin
      go_acc = cpu_req && fast_mode && (in_tgt != TGT_NONE) && (in_tgt != TGT_SLOW);
    end else if (state == ST_SWAIT && slot) begin
      go_sacc = (req_tgt == TGT_SLOW) || acc_done;
      go_acc  = !go_sacc;
    end
  end

  // Request FSM with registered bus and CPU outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= ST_IDLE;
      req_tgt    <= TGT_NONE;
      req_bank   <= '0;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_we     <= 1'b0;
      req_shadow <= 1'b0;
      acc_done   <= 1'b0;
      cpu_ready  <= 1'b0;
      cpu_rdata  <= 8'hFF;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      fast_ce    <= 1'b0;
      slow_ce    <= 1'b0;
      rom1_ce    <= 1'b0;
      rom2_ce    <= 1'b0;
    end else begin
      fast_ce   <= 1'b0;
      slow_ce   <= 1'b0;
      rom1_ce   <= 1'b0;
      rom2_ce   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_ready <= 1'b0;

      if (go_acc) begin
        fast_ce   <= (acc_tgt == TGT_FAST);
        rom1_ce   <= (acc_tgt == TGT_ROM1);
        rom2_ce   <= (acc_tgt == TGT_ROM2);
        mem_we    <= acc_we;
        mem_addr  <= target_addr(acc_tgt, acc_bank, acc_addr);
        mem_wdata <= acc_wdata;
      end
      if (go_sacc) begin
        slow_ce   <= 1'b1;
        mem_we    <= req_we;
        mem_addr  <= target_addr(TGT_SLOW, req_bank, req_addr);
        mem_wdata <= req_wdata;
      end

      case (state)
        ST_IDLE: begin
          if (cpu_req) begin
            req_tgt    <= in_tgt;
            req_bank   <= cpu_bank;
            req_addr   <= cpu_addr;
            req_wdata  <= cpu_wdata;
            req_we     <= cpu_we;
            req_shadow <= in_hit;
            acc_done   <= 1'b0;
            if (go_acc) state <= ST_ACC;
            else if (in_tgt == TGT_NONE) state <= ST_RESP;
            else state <= ST_SWAIT;
          end
        end
        ST_ACC: state <= ST_DATA;
        ST_DATA: begin
          if (!req_we) begin
            case (req_tgt)
              TGT_FAST: cpu_rdata <= fast_q;
              TGT_ROM1: cpu_rdata <= rom1_q;
              TGT_ROM2: cpu_rdata <= rom2_q;
              default:  ;
            endcase
          end
          acc_done <= 1'b1;
          if (req_shadow) begin
            state <= ST_SWAIT;
          end else begin
            state     <= ST_RESP;
            cpu_ready <= 1'b1;
          end
        end
        ST_SWAIT: begin
          if (go_sacc) state <= ST_SACC;
          else if (go_acc) state <= ST_ACC;
        end
        ST_SACC: state <= ST_SDATA;
        ST_SDATA: begin
          if (!req_we && req_tgt == TGT_SLOW) cpu_rdata <= slow_q;
          state     <= ST_RESP;
          cpu_ready <= 1'b1;
        end
        ST_RESP: begin
          // Data paths raise ready on entry; the unmapped path arrives with
          // ready low and spends one extra cycle here to raise it.
          if (cpu_ready) begin
            state <= ST_IDLE;
          end else begin
            cpu_ready <= 1'b1;
            cpu_rdata <= 8'hFF;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iigs_mem_responder.sv
// Randomized self-checking bench for iigs_mem_responder.
module tb_iigs_mem_responder;

  localparam int RAMSIZE  = 2;
  localparam int SLOW_DIV = 28;
  localparam int BUDGET   = 3 * SLOW_DIV + 12;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [7:0]  cpu_bank;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        cpu_ready;
  logic [7:0]  cpu_rdata;
  logic        fast_mode;
  logic [7:0]  shadow;
  logic [22:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        fast_ce, slow_ce, rom1_ce, rom2_ce;
  logic [7:0]  fast_q, slow_q, rom1_q, rom2_q;
  logic        slot;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [7:0] last_rd = 8'hFF;

  iigs_mem_responder #(.RAMSIZE(RAMSIZE), .SLOW_DIV(SLOW_DIV)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_bank  (cpu_bank),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_ready (cpu_ready),
    .cpu_rdata (cpu_rdata),
    .fast_mode (fast_mode),
    .shadow    (shadow),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .fast_ce   (fast_ce),
    .slow_ce   (slow_ce),
    .rom1_ce   (rom1_ce),
    .rom2_ce   (rom2_ce),
    .fast_q    (fast_q),
    .slow_q    (slow_q),
    .rom1_q    (rom1_q),
    .rom2_q    (rom2_q),
    .slot      (slot)
  );

  always #5 clk_sys = ~clk_sys;

  // Cycle index since the last reset edge; slot falls on index % SLOW_DIV == SLOW_DIV-1.
  always @(posedge clk_sys) cyc <= reset ? 0 : cyc + 1;

  // Memories present fresh random data every cycle; only the right cycle's byte is valid.
  always @(posedge clk_sys) begin
    fast_q <= 8'($urandom);
    slow_q <= 8'($urandom);
    rom1_q <= 8'($urandom);
    rom2_q <= 8'($urandom);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // 0 unmapped, 1 fast, 2 slow, 3 rom1, 4 rom2
  function automatic int model_target(input logic [7:0] bank, input logic [15:0] addr);
    if (bank == 8'hFE) return 3;
    if (bank == 8'hFF || (bank == 8'h00 && addr >= 16'hC100)) return 4;
    if (int'(bank) < RAMSIZE) return 1;
    if (bank == 8'hE0 || bank == 8'hE1) return 2;
    return 0;
  endfunction

  function automatic bit in_rng(input logic [15:0] a, input int lo, input int hi);
    return (int'(a) >= lo) && (int'(a) <= hi);
  endfunction

  function automatic bit model_shadow(input logic [7:0] bank, input logic [15:0] addr,
                                      input logic we, input logic [7:0] sh, input int tgt);
    if (!we || tgt != 1 || int'(bank) > 1) return 1'b0;
    if (bank == 8'h01 && in_rng(addr, 'h2000, 'h9FFF)) return !sh[3];
    return (in_rng(addr, 'h0400, 'h07FF) && !sh[0]) || (in_rng(addr, 'h0800, 'h0BFF) && !sh[5]) ||
           (in_rng(addr, 'h2000, 'h3FFF) && !sh[1]) || (in_rng(addr, 'h4000, 'h5FFF) && !sh[2]);
  endfunction

  function automatic logic [22:0] model_addr(input int kind, input logic [7:0] bank,
                                             input logic [15:0] addr);
    if (kind == 1) return 23'((int'(bank) % 128) * 65536 + int'(addr));
    if (kind == 2) return 23'((int'(bank) % 2) * 65536 + int'(addr));
    return 23'(addr);
  endfunction

  function automatic int next_slot(input int t);
    int s;
    s = t + 1;
    while (s % SLOW_DIV != SLOW_DIV - 1) s++;
    return s;
  endfunction

  task automatic wait_phase(input int ph);
    do @(negedge clk_sys); while (cyc % SLOW_DIV != ph);
  endtask

  // Issue one request at the current negedge, observe the bus, compare with the model.
  task automatic run_txn(input logic [7:0] bank, input logic [15:0] addr, input logic we,
                         input logic [7:0] wdata, input bit junk);
    int t0, tgt, exp_n, exp_ready, a, s, ob_n, n_ready, rdy_cyc, viol, nce, kind;
    bit hit;
    int exp_cyc[2];
    int exp_kind[2];
    logic [22:0] exp_addr[2];
    logic exp_we[2];
    int ob_cyc[4];
    int ob_kind[4];
    logic [22:0] ob_addr[4];
    logic ob_we[4];
    logic [7:0] ob_wd[4];
    logic [7:0] qlog[1:4][0:BUDGET];
    logic [7:0] rdy_data, exp_rd;

    t0 = cyc; ob_n = 0; n_ready = 0; rdy_cyc = 0; viol = 0; rdy_data = 8'h00;
    tgt = model_target(bank, addr);
    hit = model_shadow(bank, addr, we, shadow, tgt);
    cpu_req = 1'b1; cpu_bank = bank; cpu_addr = addr; cpu_we = we; cpu_wdata = wdata;

    for (int i = 1; i <= BUDGET; i++) begin
      @(negedge clk_sys);
      if (i == 1 && junk) begin
        cpu_req = 1'b1;
        cpu_bank = 8'($urandom); cpu_addr = 16'($urandom);
        cpu_we = 1'($urandom); cpu_wdata = 8'($urandom);
      end else begin
        cpu_req = 1'b0;
      end
      qlog[1][i] = fast_q; qlog[2][i] = slow_q; qlog[3][i] = rom1_q; qlog[4][i] = rom2_q;
      nce = int'(fast_ce) + int'(slow_ce) + int'(rom1_ce) + int'(rom2_ce);
      kind = fast_ce ? 1 : slow_ce ? 2 : rom1_ce ? 3 : rom2_ce ? 4 : 0;
      if (nce > 1 || (mem_we && nce == 0) ||
          (slot !== ((cyc % SLOW_DIV) == SLOW_DIV - 1))) viol++;
      if (nce > 0) begin
        if (ob_n < 4) begin
          ob_cyc[ob_n] = cyc; ob_kind[ob_n] = kind; ob_addr[ob_n] = mem_addr;
          ob_we[ob_n] = mem_we; ob_wd[ob_n] = mem_wdata;
        end
        ob_n++;
      end
      if (cpu_ready) begin
        n_ready++;
        if (n_ready == 1) begin rdy_cyc = cyc; rdy_data = cpu_rdata; end
      end
      if (n_ready > 0 && cyc >= rdy_cyc + 2) break;
    end

    exp_n = 0;
    if (tgt == 0) begin
      exp_ready = t0 + 2;
      exp_rd = 8'hFF;
    end else if (tgt == 2) begin
      s = next_slot(t0);
      exp_cyc[0] = s + 1; exp_kind[0] = 2; exp_addr[0] = model_addr(2, bank, addr); exp_we[0] = we;
      exp_n = 1;
      exp_ready = s + 3;
      exp_rd = we ? last_rd : qlog[2][s + 2 - t0];
    end else begin
      a = fast_mode ? t0 + 1 : next_slot(t0) + 1;
      exp_cyc[0] = a; exp_kind[0] = tgt; exp_addr[0] = model_addr(tgt, bank, addr); exp_we[0] = we;
      exp_n = 1;
      exp_rd = we ? last_rd : qlog[tgt][a + 1 - t0];
      if (hit) begin
        s = next_slot(a + 1);
        exp_cyc[1] = s + 1; exp_kind[1] = 2; exp_addr[1] = model_addr(2, bank, addr); exp_we[1] = 1'b1;
        exp_n = 2;
        exp_ready = s + 3;
      end else begin
        exp_ready = a + 2;
      end
    end

    check_val("ready_count", 32'(n_ready), 32'(1));
    check_val("ready_cycle", 32'(rdy_cyc - t0), 32'(exp_ready - t0));
    check_val("rdata", 32'(rdy_data), 32'(exp_rd));
    check_val("ce_count", 32'(ob_n), 32'(exp_n));
    check_val("bus_rules", 32'(viol), 32'(0));
    for (int k = 0; k < exp_n; k++) begin
      if (k < ob_n && k < 4) begin
        check_val("ce_cycle", 32'(ob_cyc[k] - t0), 32'(exp_cyc[k] - t0));
        check_val("ce_target", 32'(ob_kind[k]), 32'(exp_kind[k]));
        check_val("ce_addr", 32'(ob_addr[k]), 32'(exp_addr[k]));
        check_val("ce_we", 32'(ob_we[k]), 32'(exp_we[k]));
        if (exp_we[k]) check_val("ce_wdata", 32'(ob_wd[k]), 32'(wdata));
      end
    end
    last_rd = exp_rd;
  endtask

  // Reset while a fast_mode=0 access is waiting for its slot.
  task automatic reset_mid();
    int n_ready, n_ce;
    n_ready = 0; n_ce = 0;
    fast_mode = 1'b0; shadow = 8'h00;
    wait_phase(0);
    cpu_req = 1'b1; cpu_bank = 8'h00; cpu_addr = 16'h0000; cpu_we = 1'b0; cpu_wdata = 8'h00;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk_sys);
      cpu_req = 1'b0;
      if (i == 3) reset = 1'b1;
      if (i == 4) reset = 1'b0;
      if (cpu_ready) n_ready++;
      if (fast_ce || slow_ce || rom1_ce || rom2_ce) n_ce++;
    end
    check_val("reset_mid_ready", 32'(n_ready), 32'(0));
    check_val("reset_mid_ce", 32'(n_ce), 32'(0));
    check_val("reset_mid_rdata", 32'(cpu_rdata), 32'hFF);
    last_rd = 8'hFF;
  endtask

  initial begin
    logic [7:0]  rb;
    logic [15:0] ra;
    reset = 1'b1; cpu_req = 1'b0; cpu_bank = '0; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0;
    fast_mode = 1'b1; shadow = 8'h00;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check_val("rst_ready", 32'(cpu_ready), 32'(0));
    check_val("rst_rdata", 32'(cpu_rdata), 32'hFF);
    check_val("rst_ce", 32'({fast_ce, slow_ce, rom1_ce, rom2_ce, mem_we}), 32'(0));
    check_val("rst_addr", 32'(mem_addr), 32'(0));
    check_val("rst_wdata", 32'(mem_wdata), 32'(0));
    check_val("rst_slot", 32'(slot), 32'(0));
    reset = 1'b0;

    run_txn(8'h00, 16'h1234, 1'b0, 8'h00, 1'b0);
    shadow = 8'h00; wait_phase(3);  run_txn(8'h00, 16'h0400, 1'b1, 8'h41, 1'b0);
    shadow = 8'h01; wait_phase(3);  run_txn(8'h00, 16'h0400, 1'b1, 8'h41, 1'b0);
    shadow = 8'h08; wait_phase(7);  run_txn(8'h01, 16'h2000, 1'b1, 8'h77, 1'b0);
    shadow = 8'h00; wait_phase(7);  run_txn(8'h01, 16'h2000, 1'b1, 8'h77, 1'b0);
    shadow = 8'h02; wait_phase(7);  run_txn(8'h00, 16'h2000, 1'b1, 8'h77, 1'b0);
    shadow = 8'h00; wait_phase(SLOW_DIV - 6); run_txn(8'hE1, 16'hC000, 1'b0, 8'h00, 1'b0);
    wait_phase(SLOW_DIV - 1); run_txn(8'hE0, 16'h0123, 1'b0, 8'h00, 1'b0);
    wait_phase(SLOW_DIV - 3); run_txn(8'h00, 16'h0400, 1'b1, 8'h5A, 1'b0);
    run_txn(8'h80, 16'h0000, 1'b0, 8'h00, 1'b0);
    run_txn(8'hFE, 16'h0000, 1'b0, 8'h00, 1'b0);
    run_txn(8'h00, 16'hC100, 1'b0, 8'h00, 1'b0);
    run_txn(8'h00, 16'hC0FF, 1'b0, 8'h00, 1'b0);
    fast_mode = 1'b0; wait_phase(10); run_txn(8'h00, 16'h0000, 1'b0, 8'h00, 1'b0);
    reset_mid();
    fast_mode = 1'b1; run_txn(8'h01, 16'h4321, 1'b0, 8'h00, 1'b0);

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0, 8:    rb = 8'h00;
        1, 9:    rb = 8'h01;
        2:       rb = 8'hE0;
        3:       rb = 8'hE1;
        4:       rb = 8'hFE;
        5:       rb = 8'hFF;
        6:       rb = 8'h02;
        default: rb = 8'($urandom);
      endcase
      case ($urandom_range(0, 11))
        0:       ra = 16'h0400;
        1:       ra = 16'h07FF;
        2:       ra = 16'h0BFF;
        3:       ra = 16'h2000;
        4:       ra = 16'h3FFF;
        5:       ra = 16'h5FFF;
        6:       ra = 16'h9FFF;
        7:       ra = 16'hA000;
        8:       ra = 16'hC100;
        default: ra = 16'($urandom);
      endcase
      fast_mode = ($urandom_range(0, 3) != 0);
      shadow = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h00;
      wait_phase($urandom_range(0, SLOW_DIV - 1));
      run_txn(rb, ra, 1'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
